// File: rtl/seg7_scan_capture.sv
// Captures the value shown on a multiplexed 8-digit seven-segment display by
// sampling each digit once its select/segment lines settle and decoding the glyph.
module seg7_scan_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  num_csn,
    input  logic [6:0]  num_a_g,
    output logic [31:0] value,
    output logic        frame_valid,
    output logic [7:0]  digit_seen,
    output logic        sel_err,
    output logic        seg_err
);

    localparam int unsigned NDIG     = 8;
    localparam int unsigned CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(STABLE_CYCLES - 1);

    logic [7:0]       sync_csn;
    logic [6:0]       sync_seg;
    logic [7:0]       s_csn;
    logic [6:0]       s_seg;
    logic [7:0]       p_csn;
    logic [6:0]       p_seg;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       fill;
    logic [31:0]      shadow;

    logic        primed;
    logic        changed;
    logic        fire;
    logic        blank;
    logic [7:0]  sel;
    logic        one_low;
    logic        multi_low;
    logic [3:0]  nib;
    logic        legal;
    logic [31:0] merged;
    logic [7:0]  seen_next;
    logic        record;

    // Suppress events until the synchronizer and previous-value register hold real input.
    assign primed    = (fill == 2'd3);
    assign changed   = ({s_csn, s_seg} != {p_csn, p_seg});
    assign fire      = primed && !changed && (cnt == CNT_FIRE);
    assign blank     = &s_csn;
    assign sel       = ~s_csn;
    assign one_low   = $onehot(sel);
    assign multi_low = !blank && !one_low;
    assign seen_next = digit_seen | sel;
    assign record    = fire && one_low && legal;

    always_comb begin
        nib   = 4'h0;
        legal = 1'b1;
        case (s_seg)
            7'h7E: nib = 4'h0;
            7'h30: nib = 4'h1;
            7'h6D: nib = 4'h2;
            7'h79: nib = 4'h3;
            7'h33: nib = 4'h4;
            7'h5B: nib = 4'h5;
            7'h5F: nib = 4'h6;
            7'h70: nib = 4'h7;
            7'h7F: nib = 4'h8;
            7'h7B: nib = 4'h9;
            7'h77: nib = 4'hA;
            7'h1F: nib = 4'hB;
            7'h4E: nib = 4'hC;
            7'h3D: nib = 4'hD;
            7'h4F: nib = 4'hE;
            7'h47: nib = 4'hF;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        merged = shadow;
        for (int i = 0; i < NDIG; i++) begin
            if (sel[i]) merged[4*i +: 4] = nib;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_csn    <= '0;
            sync_seg    <= '0;
            s_csn       <= '0;
            s_seg       <= '0;
            p_csn       <= '0;
            p_seg       <= '0;
            cnt         <= '0;
            fill        <= '0;
            shadow      <= '0;
            value       <= '0;
            frame_valid <= 1'b0;
            digit_seen  <= '0;
            sel_err     <= 1'b0;
            seg_err     <= 1'b0;
        end else begin
            sync_csn <= num_csn;
            sync_seg <= num_a_g;
            s_csn    <= sync_csn;
            s_seg    <= sync_seg;
            p_csn    <= s_csn;
            p_seg    <= s_seg;
            if (!primed) fill <= fill + 2'd1;

            if (!primed || changed)   cnt <= '0;
            else if (cnt != CNT_MAX)  cnt <= cnt + CNT_W'(1);

            frame_valid <= 1'b0;
            sel_err     <= fire && multi_low;
            seg_err     <= fire && one_low && !legal;

            if (record) begin
                shadow <= merged;
                if (seen_next == 8'hFF) begin
                    value       <= merged;
                    frame_valid <= 1'b1;
                    digit_seen  <= '0;
                end else begin
                    digit_seen  <= seen_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: scans digits in several orders and
// checks captured value, frame pulse timing, error pulses and reset.
module tb_seg7_scan_capture;

    logic        clk;
    logic        rst;
    logic [7:0]  num_csn;
    logic [6:0]  num_a_g;
    logic [31:0] value;
    logic        frame_valid;
    logic [7:0]  digit_seen;
    logic        sel_err;
    logic        seg_err;

    int tests;
    int fails;
    int fv_cnt;
    int sel_cnt;
    int seg_cnt;

    seg7_scan_capture #(.STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .num_csn     (num_csn),
        .num_a_g     (num_a_g),
        .value       (value),
        .frame_valid (frame_valid),
        .digit_seen  (digit_seen),
        .sel_err     (sel_err),
        .seg_err     (seg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) fv_cnt++;
        if (sel_err === 1'b1)     sel_cnt++;
        if (seg_err === 1'b1)     seg_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int idx, input logic [6:0] seg, input int cycles);
        logic [7:0] c;
        c = 8'hFF;
        c[idx] = 1'b0;
        num_csn = c;
        num_a_g = seg;
        repeat (cycles) tick();
    endtask

    task automatic test_reset();
        num_csn = 8'hFF;
        num_a_g = 7'h00;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            tests++;
            if ({value, frame_valid, digit_seen, sel_err, seg_err} !== 43'd0) begin
                fails++;
                $display("FAIL reset_idle cycle %0d: value=%h fv=%b seen=%h sel=%b seg=%b, want all zero",
                         i, value, frame_valid, digit_seen, sel_err, seg_err);
            end
        end
    endtask

    task automatic test_scan_ascending();
        logic [6:0] segs [8];
        int f0, e0, s0, lat;
        segs = '{7'h7F, 7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30};
        f0 = fv_cnt; e0 = seg_cnt; s0 = sel_cnt;
        for (int d = 0; d < 7; d++) drive(d, segs[d], 10);
        tests++;
        if (digit_seen !== 8'h7F) begin
            fails++;
            $display("FAIL asc_seen_before_last: got %h want 7f", digit_seen);
        end
        drive(7, segs[7], 0);
        lat = -1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (frame_valid === 1'b1 && lat < 0) lat = e;
        end
        tests++;
        if (lat != 7) begin
            fails++;
            $display("FAIL asc_latency: got %0d edges want 7", lat);
        end
        tests++;
        if (value !== 32'h12345678) begin
            fails++;
            $display("FAIL asc_value: got %h want 12345678", value);
        end
        tests++;
        if (fv_cnt - f0 != 1) begin
            fails++;
            $display("FAIL asc_pulses: got %0d frame pulses want 1", fv_cnt - f0);
        end
        tests++;
        if (digit_seen !== 8'h00 || seg_cnt != e0 || sel_cnt != s0) begin
            fails++;
            $display("FAIL asc_after: seen=%h seg_err=%0d sel_err=%0d, want 00 0 0",
                     digit_seen, seg_cnt - e0, sel_cnt - s0);
        end
    endtask

    task automatic test_scan_descending();
        logic [6:0] segs [8];
        logic [7:0] walk [8];
        int f0;
        segs = '{7'h47, 7'h4F, 7'h4F, 7'h1F, 7'h3D, 7'h77, 7'h4F, 7'h3D};
        walk = '{8'h00, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
        f0 = fv_cnt;
        for (int d = 7; d >= 0; d--) begin
            drive(d, segs[d], 10);
            tests++;
            if (digit_seen !== walk[d]) begin
                fails++;
                $display("FAIL desc_seen digit %0d: got %h want %h", d, digit_seen, walk[d]);
            end
        end
        tests++;
        if (value !== 32'hDEADBEEF || fv_cnt - f0 != 1) begin
            fails++;
            $display("FAIL desc_value: got %h pulses %0d want deadbeef pulses 1", value, fv_cnt - f0);
        end
    endtask

    task automatic test_seg_err();
        logic [6:0] segs [8];
        int f0, e0;
        segs = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70};
        f0 = fv_cnt; e0 = seg_cnt;
        for (int d = 0; d < 3; d++) drive(d, segs[d], 10);
        drive(3, 7'h01, 10);
        tests++;
        if (seg_cnt - e0 != 1 || digit_seen !== 8'h07) begin
            fails++;
            $display("FAIL segerr_pulse: got %0d pulses seen=%h want 1 pulse seen=07", seg_cnt - e0, digit_seen);
        end
        for (int d = 4; d < 8; d++) drive(d, segs[d], 10);
        tests++;
        if (digit_seen !== 8'hF7 || fv_cnt != f0) begin
            fails++;
            $display("FAIL segerr_no_frame: seen=%h pulses=%0d want f7 0", digit_seen, fv_cnt - f0);
        end
        drive(3, segs[3], 10);
        tests++;
        if (value !== 32'h76543210 || fv_cnt - f0 != 1 || seg_cnt - e0 != 1) begin
            fails++;
            $display("FAIL segerr_recover: value=%h pulses=%0d segerr=%0d want 76543210 1 1",
                     value, fv_cnt - f0, seg_cnt - e0);
        end
    endtask

    task automatic test_sel_err();
        int s0, e0, f0;
        s0 = sel_cnt; e0 = seg_cnt; f0 = fv_cnt;
        num_csn = 8'hFC;
        num_a_g = 7'h7E;
        repeat (10) tick();
        tests++;
        if (sel_cnt - s0 != 1 || seg_cnt != e0 || fv_cnt != f0) begin
            fails++;
            $display("FAIL selerr_pulse: sel=%0d seg=%0d fv=%0d want 1 0 0", sel_cnt - s0, seg_cnt - e0, fv_cnt - f0);
        end
        tests++;
        if (digit_seen !== 8'h00 || value !== 32'h76543210) begin
            fails++;
            $display("FAIL selerr_state: seen=%h value=%h want 00 76543210", digit_seen, value);
        end
    endtask

    task automatic test_glitch();
        int s0, e0, f0;
        drive(0, 7'h7B, 10);
        s0 = sel_cnt; e0 = seg_cnt; f0 = fv_cnt;
        drive(0, 7'h01, 2);
        drive(0, 7'h7B, 12);
        tests++;
        if (sel_cnt != s0 || seg_cnt != e0 || fv_cnt != f0 || digit_seen !== 8'h01) begin
            fails++;
            $display("FAIL glitch: sel=%0d seg=%0d fv=%0d seen=%h want 0 0 0 01",
                     sel_cnt - s0, seg_cnt - e0, fv_cnt - f0, digit_seen);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [6:0] segs [8];
        int f0;
        segs = '{7'h5B, 7'h30, 7'h4F, 7'h4F, 7'h47, 7'h47, 7'h7E, 7'h4E};
        for (int d = 0; d < 5; d++) drive(d, segs[d], 10);
        tests++;
        if (digit_seen !== 8'h1F) begin
            fails++;
            $display("FAIL mid_seen_before: got %h want 1f", digit_seen);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (digit_seen !== 8'h00 || value !== 32'h0) begin
            fails++;
            $display("FAIL mid_reset: seen=%h value=%h want 00 00000000", digit_seen, value);
        end
        repeat (2) tick();
        rst = 1'b0;
        f0 = fv_cnt;
        for (int d = 0; d < 8; d++) drive(d, segs[d], 10);
        tests++;
        if (value !== 32'hC0FFEE15 || fv_cnt - f0 != 1 || digit_seen !== 8'h00) begin
            fails++;
            $display("FAIL mid_rescan: value=%h pulses=%0d seen=%h want c0ffee15 1 00",
                     value, fv_cnt - f0, digit_seen);
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        fv_cnt = 0; sel_cnt = 0; seg_cnt = 0;
        rst = 1'b1;
        num_csn = 8'hFF;
        num_a_g = 7'h00;
        test_reset();
        test_scan_ascending();
        test_scan_descending();
        test_seg_err();
        test_sel_err();
        test_glitch();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
